// File: rtl/rdp_pkg.sv
// Shared definitions for the RDP parity encoder: FSM state type, datapath width
// and the rotate-left helper used for diagonal parity.
package rdp_pkg;

   localparam int DAT_W = 512;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FINAL = 2'd1,
      OUT   = 2'd2
   } state_t;

   // Rotate left by n mod DAT_W; the zero case avoids a full-width right shift.
   function automatic logic [DAT_W-1:0] rotl(input logic [DAT_W-1:0] x,
                                            input int unsigned     n);
      int unsigned s;
      s = n % DAT_W;
      if (s == 0) return x;
      return (x << s) | (x >> (DAT_W - s));
   endfunction

endpackage

// File: rtl/rdp_rotl.sv
// Combinational rotate-left of a W-bit word by a run-time amount (mod W).
// W must be a power of two so the amount wraps naturally in SHIFT_W bits.
module rdp_rotl
   import rdp_pkg::*;
#(
   parameter int W       = DAT_W,
   parameter int SHIFT_W = $clog2(W)
) (
   input  logic [W-1:0]       x,
   input  logic [SHIFT_W-1:0] amt,
   output logic [W-1:0]       y
);

   // For amt == 0 the right shift by W yields zero, leaving y == x.
   assign y = (x << amt) | (x >> (W - 32'(amt)));

endmodule

// File: rtl/rdp_parity_encoder.sv
// RDP stripe encoder: accumulates NDISK data beats into row parity P and
// diagonal parity Q. Optional handshake counter enabled by RDP_ENC_STRIPE_CNT_EN.
module rdp_parity_encoder
   import rdp_pkg::*;
#(
   parameter int NDISK = 4,
   parameter int SYM_W = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DAT_W-1:0] t_dat,
   input  logic             t_valid,
   output logic             t_ready,
   output logic [DAT_W-1:0] i_p_dat,
   output logic [DAT_W-1:0] i_q_dat,
   output logic             i_valid,
   input  logic             i_ready
`ifdef RDP_ENC_STRIPE_CNT_EN
   ,
   output logic [15:0]      i_stripe_cnt
`endif
);

   localparam int          ROT_W     = $clog2(DAT_W);
   localparam logic [3:0]  LAST_BEAT = 4'(NDISK - 1);
   localparam int unsigned FOLD_ROT  = 32'((NDISK * SYM_W) % DAT_W);

   generate
      if (NDISK < 2 || NDISK > 15 || (DAT_W % SYM_W) != 0) begin : g_bad_param
         $error("rdp_parity_encoder: NDISK must be 2..15 and SYM_W must divide 512");
      end
   endgenerate

   state_t           state;
   logic [3:0]       cnt;
   logic [DAT_W-1:0] p_acc;
   logic [DAT_W-1:0] q_acc;
   logic [31:0]      rot_full;
   logic [ROT_W-1:0] rot_amt;
   logic [DAT_W-1:0] beat_rot;

   // Beat d lands on diagonal offset d*SYM_W; wrap mod 512 is the low bits.
   assign rot_full = 32'(cnt) * 32'(SYM_W);
   assign rot_amt  = rot_full[ROT_W-1:0];

   rdp_rotl #(.W(DAT_W), .SHIFT_W(ROT_W)) u_beat_rotl (
      .x   (t_dat),
      .amt (rot_amt),
      .y   (beat_rot)
   );

   assign t_ready = (state == ACCUM);
   assign i_valid = (state == OUT);
   assign i_p_dat = p_acc;
   assign i_q_dat = q_acc;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; the wide accumulators are plain registers and are reset
   // so the parity outputs read zero after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ACCUM;
         cnt   <= '0;
         p_acc <= '0;
         q_acc <= '0;
      end else begin
         // NOTE: the default arm returns an unused encoding to a safe state.
         case (state)
            ACCUM: begin
               if (t_valid) begin
                  p_acc <= p_acc ^ t_dat;
                  q_acc <= q_acc ^ beat_rot;
                  if (cnt == LAST_BEAT) begin
                     cnt   <= '0;
                     state <= FINAL;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            FINAL: begin
               q_acc <= q_acc ^ rotl(p_acc, FOLD_ROT);
               state <= OUT;
            end
            OUT: begin
               if (i_ready) begin
                  p_acc <= '0;
                  q_acc <= '0;
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

`ifdef RDP_ENC_STRIPE_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_stripe_cnt <= '0;
      end else if (i_valid && i_ready) begin
         i_stripe_cnt <= i_stripe_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/rdp_parity_encoder.md
RDP_PARITY_ENCODER -- requirements
Module: rdp_parity_encoder

Interface
REQ-001 SHALL have parameter NDISK, default 4, meaning data beats per stripe; legal range 2..15.
REQ-002 SHALL have parameter SYM_W, default 64, meaning diagonal rotation step in bits; must divide 512.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port t_dat  input  512  one data-disk beat.
REQ-006 SHALL have port t_valid  input  1  t_dat valid.
REQ-007 SHALL have port t_ready  output  1  encoder accepts a beat.
REQ-008 SHALL have port i_p_dat  output  512  row parity P.
REQ-009 SHALL have port i_q_dat  output  512  diagonal parity Q.
REQ-010 SHALL have port i_valid  output  1  P/Q valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts P/Q.

Function
REQ-012 SHALL accept a beat only on a cycle with t_valid=1 and t_ready=1.
REQ-013 SHALL define rotl(x,n) as a 512-bit rotate left by n mod 512 bits.
REQ-014 SHALL compute P = XOR of D0..D(NDISK-1), where Dd is the d-th accepted beat of the stripe.
REQ-015 SHALL compute Q = XOR over d of rotl(Dd, d*SYM_W), XOR rotl(P, NDISK*SYM_W).
REQ-016 SHALL implement three states: ACCUM, FINAL, OUT.
REQ-017 ACCUM SHALL drive t_ready=1 and i_valid=0, and XOR each accepted beat into the P and Q accumulators.
REQ-018 ACCUM SHALL count accepted beats with a 4-bit counter; acceptance at count NDISK-1 SHALL move to FINAL and clear the counter.
REQ-019 FINAL SHALL last exactly one cycle with t_ready=0, and SHALL fold rotl(P, NDISK*SYM_W) into Q.
REQ-020 OUT SHALL drive i_valid=1 with i_p_dat and i_q_dat held stable and t_ready=0 until i_ready=1.
REQ-021 On an i_ready=1 handshake in OUT, the block SHALL clear both accumulators and return to ACCUM next cycle.
REQ-022 Latency: last beat accepted at cycle N SHALL give i_valid=1 at cycle N+2; the minimum stripe period is NDISK+2 cycles.
REQ-023 ACCUM SHALL not advance state while t_valid=0, and SHALL impose no bubble on back-to-back beats.
REQ-024 i_ready SHALL be ignored outside OUT; t_valid SHALL be ignored outside ACCUM.

Reset
REQ-025 reset_n=0 SHALL asynchronously force the state to ACCUM, the counter to 0, the P and Q accumulators to 0, t_ready=1, i_valid=0, i_p_dat=0 and i_q_dat=0.
REQ-026 Reset in mid-stripe or in OUT SHALL discard partial or pending parity, with no output afterwards.

Configuration
REQ-027 With macro RDP_ENC_STRIPE_CNT_EN defined, the block SHALL add output port i_stripe_cnt  output  16  count of completed output handshakes, wrapping 0xFFFF->0, reset to 0.
REQ-028 Without RDP_ENC_STRIPE_CNT_EN, that port and counter SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-029 Package rdp_pkg SHALL hold the state enum (ACCUM, FINAL, OUT), the DAT_W=512 constant and the rotl function.
REQ-030 Sub-module rdp_rotl SHALL implement the combinational parameterised rotator; accumulators, counter and FSM stay in the top module.

Verification
REQ-031 NDISK=4, SYM_W=64, beats 1,2,4,8 (LSB-aligned) with i_ready=1 -> P=0xF; Q=rotl(1,0)^rotl(2,64)^rotl(4,128)^rotl(8,192)^rotl(0xF,256); i_valid rises 2 cycles after the 4th accept.
REQ-032 All-ones beats with NDISK=4 -> P=0 and Q=0.
REQ-033 i_ready held 0 for 10 cycles in OUT -> outputs stable, t_ready=0 throughout; i_ready=1 -> t_ready=1 the next cycle.
REQ-034 t_valid toggled 1,0,1,0 -> accumulation completes after 4 accepted beats only; result matches the gapless run.
REQ-035 reset_n pulsed low after 2 beats, then 4 fresh beats -> P/Q reflect only the fresh beats.
REQ-036 With RDP_ENC_STRIPE_CNT_EN, 65537 stripes -> i_stripe_cnt=1.
